mem_arbiter: RTL and testbench

- Sits between the I/D cache pair and the single-ported RAM.
- Shares one RAM port between the instruction-fetch requester and the data requester.
- Grants one requester at a time, holds the grant until the RAM completes, and generates the per-requester wait signals.
- Data has priority by default; an optional fairness mode bounds instruction starvation.

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory-side types: RAM status codes, machine word, arbiter states.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares the single RAM port between instruction fetch and data access; data first.
// Optional instruction-starvation bound enabled with `define MEM_ARB_FAIR_EN.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              err
);

    arb_state_t r_state;
    logic       r_err;

    ramstate_t  w_rs;
    logic       w_d_req;
    logic       w_access;
    logic       w_error;
    logic       w_d_done;
    logic       w_i_done;
    logic       w_fair_go;

    assign w_rs     = ramstate_t'(ramstate);
    assign w_d_req  = dREN | dWEN;
    assign w_access = (w_rs == ACCESS);
    assign w_error  = (w_rs == ERROR);
    // A completion needs the owner still requesting; a dropped request is an abort.
    assign w_d_done = (r_state == GNT_D) & w_d_req & w_access;
    assign w_i_done = (r_state == GNT_I) & iREN & w_access;

    assign iload = ramload;
    assign dload = ramload;
    assign err   = r_err;

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (r_state)
            GNT_D: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dwait    = ~w_d_done;
            end
            GNT_I: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                iwait   = ~w_i_done;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fair_go)     r_state <= GNT_I;
                    else if (w_d_req)  r_state <= GNT_D;
                    else if (iREN)     r_state <= GNT_I;
                end
                GNT_D: begin
                    if (w_error) r_err <= 1'b1;
                    if (!w_d_req || w_access || w_error) r_state <= IDLE;
                end
                GNT_I: begin
                    if (w_error) r_err <= 1'b1;
                    if (!iREN || w_access || w_error) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_FAIR_EN
    logic [2:0] r_starve;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_starve <= '0;
        end else if (!iREN || w_i_done) begin
            r_starve <= '0;
        end else if (w_d_done && r_starve != 3'd7) begin
            r_starve <= r_starve + 3'd1;
        end
    end

    assign w_fair_go = iREN & (r_starve >= 3'(STARVE_LIMIT));
`else
    logic w_unused_limit;
    assign w_unused_limit = |STARVE_LIMIT;
    assign w_fair_go      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; fairness checks follow MEM_ARB_FAIR_EN.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
    logic [1:0]  ramstate = 2'(FREE);
    logic        iwait, dwait, ramREN, ramWEN, err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int n_total = 0;
    int n_bad   = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    int  dcnt;
    logic igrant;

    initial begin
        // reset state
        #12;
        chk("rst_ramREN", ramREN, 0);
        chk("rst_ramWEN", ramWEN, 0);
        chk("rst_iwait", iwait, 1);
        chk("rst_dwait", dwait, 1);
        chk("rst_ramaddr", ramaddr, 0);
        chk("rst_ramstore", ramstore, 0);
        chk("rst_err", err, 0);
        RST = 1'b0;
        tick();

        // instruction read, two BUSY cycles then ACCESS
        iREN = 1; iaddr = 32'h40; #1;
        chk("i_idle_ren", ramREN, 0);
        tick(); ramstate = 2'(BUSY); #1;
        chk("i_ren", ramREN, 1);
        chk("i_addr", ramaddr, 32'h40);
        chk("i_wait_busy1", iwait, 1);
        tick(); #1;
        chk("i_wait_busy2", iwait, 1);
        tick(); ramstate = 2'(ACCESS); ramload = 32'hDEADBEEF; #1;
        chk("i_wait_done", iwait, 0);
        chk("i_load", iload, 32'hDEADBEEF);
        chk("i_dwait", dwait, 1);
        tick(); iREN = 0; ramstate = 2'(FREE); #1;
        chk("i_back_idle_ren", ramREN, 0);
        chk("i_back_idle_wait", iwait, 1);

        // simultaneous I and D-write: D first
        iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h80; dstore = 32'h1234;
        tick(); ramstate = 2'(BUSY); #1;
        chk("dw_wen", ramWEN, 1);
        chk("dw_ren", ramREN, 0);
        chk("dw_addr", ramaddr, 32'h80);
        chk("dw_store", ramstore, 32'h1234);
        chk("dw_iwait", iwait, 1);
        ramstate = 2'(ACCESS); #1;
        chk("dw_dwait_done", dwait, 0);
        chk("dw_iwait_done", iwait, 1);
        tick(); dWEN = 0; ramstate = 2'(FREE); #1;
        chk("dw_idle_wen", ramWEN, 0);
        tick(); #1;
        chk("dwi_ren", ramREN, 1);
        chk("dwi_addr", ramaddr, 32'h44);
        chk("dwi_iwait_hold", iwait, 1);
        ramstate = 2'(ACCESS); ramload = 32'hCAFE; #1;
        chk("dwi_iwait_done", iwait, 0);
        chk("dwi_iload", iload, 32'hCAFE);
        tick(); iREN = 0; ramstate = 2'(FREE); #1;

        // dREN and dWEN together: write wins
        dREN = 1; dWEN = 1; daddr = 32'h90;
        tick(); ramstate = 2'(BUSY); #1;
        chk("rw_wen", ramWEN, 1);
        chk("rw_ren", ramREN, 0);
        ramstate = 2'(ACCESS); ramload = 32'h5555; #1;
        chk("rw_dwait", dwait, 0);
        chk("rw_dload", dload, 32'h5555);
        tick(); dREN = 0; dWEN = 0; ramstate = 2'(FREE); #1;

        // ERROR during instruction grant, then retry
        iREN = 1; iaddr = 32'h48;
        tick(); ramstate = 2'(ERROR); #1;
        chk("er_iwait", iwait, 1);
        chk("er_err_pre", err, 0);
        tick(); ramstate = 2'(FREE); #1;
        chk("er_err_set", err, 1);
        chk("er_idle_ren", ramREN, 0);
        chk("er_idle_iwait", iwait, 1);
        tick(); #1;
        chk("er_regrant_ren", ramREN, 1);
        ramstate = 2'(ACCESS); #1;
        chk("er_retry_iwait", iwait, 0);
        tick(); iREN = 0; ramstate = 2'(FREE); #1;
        chk("er_err_sticky", err, 1);

        // data read abort before ACCESS
        dREN = 1; daddr = 32'hA0;
        tick(); ramstate = 2'(BUSY); #1;
        chk("ab_ren", ramREN, 1);
        dREN = 0; #1;
        chk("ab_ren_drop", ramREN, 0);
        chk("ab_dwait", dwait, 1);
        tick(); ramstate = 2'(ACCESS); #1;
        chk("ab_idle_dwait", dwait, 1);
        chk("ab_idle_addr", ramaddr, 0);
        ramstate = 2'(FREE);

        // async reset in the middle of a data grant
        dWEN = 1; daddr = 32'hB0; dstore = 32'h77;
        tick(); ramstate = 2'(BUSY); #1;
        chk("ar_wen_pre", ramWEN, 1);
        #2 RST = 1; #1;
        chk("ar_wen", ramWEN, 0);
        chk("ar_addr", ramaddr, 0);
        chk("ar_store", ramstore, 0);
        chk("ar_err", err, 0);
        chk("ar_dwait", dwait, 1);
        dWEN = 0; ramstate = 2'(FREE);
        tick(); RST = 0;
        tick();

        // continuous data reads with an instruction request pending
        dREN = 1; iREN = 1; daddr = 32'hC0; iaddr = 32'h50;
        dcnt = 0; igrant = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            ramstate = (ramREN | ramWEN) ? 2'(ACCESS) : 2'(FREE);
            #1;
            if (!dwait) dcnt++;
            if (!iwait) begin
                igrant = 1;
                break;
            end
        end
`ifdef MEM_ARB_FAIR_EN
        chk("fair_igrant", igrant, 1);
        chk("fair_dcnt", dcnt, 4);
`else
        chk("strict_igrant", igrant, 0);
        chk("strict_dcnt", dcnt, 15);
`endif
        dREN = 0; iREN = 0; ramstate = 2'(FREE);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
